// File: rtl/gpio_wave_seq.sv
// GPIO waveform sequencer: plays queued, timed masked-output writes
// onto the GPIO masked-out strobe/mask/data path.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   cmd_valid_i/cmd_ready_o  step push handshake
//   cmd_upper_i              0 = pins 15:0, 1 = pins 31:16
//   cmd_mask_i, cmd_data_i   masked-write fields of the step
//   cmd_hold_i               extra cycles to hold after the write
//   start_i, abort_i         playback control pulses
//   mo_lower_qe_o/upper_qe_o write strobes (registered, one-hot)
//   mo_mask_o, mo_data_o     fields for the active strobe, else 0
//   busy_o, done_o, level_o  status and FIFO occupancy
module gpio_wave_seq #(
    parameter int Depth = 8,
    parameter int HoldW = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic                       cmd_upper_i,
    input  logic [15:0]                cmd_mask_i,
    input  logic [15:0]                cmd_data_i,
    input  logic [HoldW-1:0]           cmd_hold_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    output logic                       mo_lower_qe_o,
    output logic                       mo_upper_qe_o,
    output logic [15:0]                mo_mask_o,
    output logic [15:0]                mo_data_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(Depth):0]     level_o
);

    localparam int AW = $clog2(Depth);
    localparam int LW = AW + 1;
    localparam int EW = 33 + HoldW;
    localparam logic [LW-1:0] FullLvl = LW'(Depth);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [EW-1:0]    mem [Depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [1:0]       state;
    logic [HoldW-1:0] cnt;

    logic             push;
    logic             pop;
    logic             finish;
    logic             step_end;
    logic             has_next;

    logic             head_upper;
    logic [15:0]      head_mask;
    logic [15:0]      head_data;
    logic [HoldW-1:0] head_hold;

    assign cmd_ready_o = (level < FullLvl);
    assign level_o     = level;
    assign busy_o      = (state != IDLE);
    assign has_next    = (level != '0);

    // Abort swallows any push presented in the same cycle.
    assign push = cmd_valid_i && cmd_ready_o && !abort_i;

    assign {head_upper, head_mask, head_data, head_hold} = mem[rd_ptr];

    // The current step's time is used up at the end of this cycle:
    // either a zero-hold ISSUE or the last HOLD cycle (counter at 1).
    always_comb begin
        step_end = 1'b0;
        unique case (state)
            ISSUE:   step_end = (cnt == '0);
            HOLD:    step_end = (cnt == HoldW'(1));
            default: step_end = 1'b0;
        endcase
    end

    // Popping the head and registering its strobe happen on the same
    // edge, so the write appears in the cycle the FSM reads ISSUE.
    assign pop    = !abort_i && has_next &&
                    (((state == IDLE) && start_i) || step_end);
    assign finish = !abort_i && !has_next && step_end;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_upper_i, cmd_mask_i, cmd_data_i, cmd_hold_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (abort_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            cnt           <= '0;
            mo_lower_qe_o <= 1'b0;
            mo_upper_qe_o <= 1'b0;
            mo_mask_o     <= '0;
            mo_data_o     <= '0;
            done_o        <= 1'b0;
        end else begin
            mo_lower_qe_o <= 1'b0;
            mo_upper_qe_o <= 1'b0;
            mo_mask_o     <= '0;
            mo_data_o     <= '0;
            done_o        <= 1'b0;
            if (abort_i) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (pop) begin
                state         <= ISSUE;
                cnt           <= head_hold;
                mo_lower_qe_o <= !head_upper;
                mo_upper_qe_o <= head_upper;
                mo_mask_o     <= head_mask;
                mo_data_o     <= head_data;
            end else if (finish) begin
                state  <= IDLE;
                done_o <= 1'b1;
            end else begin
                unique case (state)
                    ISSUE:   state <= HOLD;
                    HOLD:    cnt   <= cnt - HoldW'(1);
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpio_wave_seq.sv
// Self-checking bench for gpio_wave_seq: table-driven playback runs,
// scoreboard of expected strobes, hand-written corner sequences.
module tb_gpio_wave_seq;

    logic        clk_i;
    logic        rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_upper_i;
    logic [15:0] cmd_mask_i;
    logic [15:0] cmd_data_i;
    logic [15:0] cmd_hold_i;
    logic        start_i;
    logic        abort_i;
    logic        mo_lower_qe_o;
    logic        mo_upper_qe_o;
    logic [15:0] mo_mask_o;
    logic [15:0] mo_data_o;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  level_o;

    gpio_wave_seq #(.Depth(8), .HoldW(16)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_upper_i   (cmd_upper_i),
        .cmd_mask_i    (cmd_mask_i),
        .cmd_data_i    (cmd_data_i),
        .cmd_hold_i    (cmd_hold_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .mo_lower_qe_o (mo_lower_qe_o),
        .mo_upper_qe_o (mo_upper_qe_o),
        .mo_mask_o     (mo_mask_o),
        .mo_data_o     (mo_data_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .level_o       (level_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic        up;
        logic [15:0] m;
        logic [15:0] d;
        int          hold;
        logic        exp_lo;
        logic        exp_up;
    } vec_t;

    typedef struct {
        logic        lo;
        logic        up;
        logic [15:0] m;
        logic [15:0] d;
    } exp_t;

    vec_t tbl [8];
    exp_t exp_q [$];
    int   st_q [$];
    int   dn_q [$];
    int   cyc;
    int   errors;
    int   checks;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // One clock: advance, then sample just after the edge and score it.
    task automatic tick();
        exp_t e;
        @(posedge clk_i);
        #1;
        cyc++;
        if (mo_lower_qe_o || mo_upper_qe_o) begin
            chk("onehot", int'(mo_lower_qe_o && mo_upper_qe_o), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_lo", int'(mo_lower_qe_o), int'(e.lo));
                chk("strobe_up", int'(mo_upper_qe_o), int'(e.up));
                chk("mask", int'(mo_mask_o), int'(e.m));
                chk("data", int'(mo_data_o), int'(e.d));
            end
            st_q.push_back(cyc);
        end else begin
            chk("idle_md_zero", int'(mo_mask_o | mo_data_o), 0);
        end
        if (done_o) begin
            dn_q.push_back(cyc);
        end
    endtask

    task automatic push(input logic up, input logic [15:0] m,
                        input logic [15:0] d, input int h);
        logic acc;
        exp_t e;
        cmd_valid_i = 1'b1;
        cmd_upper_i = up;
        cmd_mask_i  = m;
        cmd_data_i  = d;
        cmd_hold_i  = 16'(h);
        acc = cmd_ready_o;
        tick();
        cmd_valid_i = 1'b0;
        if (acc) begin
            e.lo = !up;
            e.up = up;
            e.m  = m;
            e.d  = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int budget);
        int b;
        b = budget;
        while (dn_q.size() == 0 && b > 0) begin
            tick();
            b--;
        end
        if (dn_q.size() == 0) begin
            chk("done_timeout", 0, 1);
        end
    endtask

    // Push table entries [first, first+n), start, and check strobe
    // times against t+1, then +1+hold per step, and done after last.
    task automatic play(input int first, input int n);
        int t;
        int et;
        int bc;
        int bexp;
        int b;
        exp_t e;
        st_q.delete();
        dn_q.delete();
        bexp = 0;
        for (int i = 0; i < n; i++) begin
            push(tbl[first+i].up, tbl[first+i].m, tbl[first+i].d,
                 tbl[first+i].hold);
            e = exp_q.pop_back();
            e.lo = tbl[first+i].exp_lo;
            e.up = tbl[first+i].exp_up;
            exp_q.push_back(e);
            bexp += 1 + tbl[first+i].hold;
        end
        chk("level_loaded", int'(level_o), n);
        start_i = 1'b1;
        t = cyc;
        tick();
        start_i = 1'b0;
        bc = int'(busy_o);
        b = bexp + 20;
        while (dn_q.size() == 0 && b > 0) begin
            tick();
            b--;
            if (busy_o) bc++;
            if (done_o) chk("busy_at_done", int'(busy_o), 0);
        end
        if (dn_q.size() == 0) chk("play_timeout", 0, 1);
        for (int i = 0; i < 3; i++) tick();
        chk("busy_cycles", bc, bexp);
        chk("strobe_count", st_q.size(), n);
        et = t + 1;
        for (int i = 0; i < n; i++) begin
            if (i < st_q.size()) chk("strobe_time", st_q[i], et);
            et += 1 + tbl[first+i].hold;
        end
        chk("done_count", dn_q.size(), 1);
        if (dn_q.size() > 0) chk("done_time", dn_q[0], et);
        chk("level_end", int'(level_o), 0);
        chk("busy_end", int'(busy_o), 0);
    endtask

    initial begin
        int t;
        int ts;
        errors      = 0;
        checks      = 0;
        cyc         = 0;
        rst_ni      = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_upper_i = 1'b0;
        cmd_mask_i  = '0;
        cmd_data_i  = '0;
        cmd_hold_i  = '0;
        start_i     = 1'b0;
        abort_i     = 1'b0;

        tbl[0] = '{1'b0, 16'h00FF, 16'h00A5, 3, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 16'hFFFF, 16'h1234, 0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 16'h0F0F, 16'hABCD, 0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 16'h8001, 16'hFFFF, 0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 16'hFFFF, 16'h0000, 1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 16'h0001, 16'h0001, 2, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 16'hF000, 16'h5A5A, 0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 16'hFFFF, 16'hFFFF, 7, 1'b0, 1'b1};

        // Reset values
        tick();
        tick();
        chk("rst_ready", int'(cmd_ready_o), 1);
        chk("rst_level", int'(level_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_lo", int'(mo_lower_qe_o), 0);
        chk("rst_up", int'(mo_upper_qe_o), 0);
        rst_ni = 1'b1;
        tick();

        // Table-driven playback runs
        play(0, 1);
        play(1, 3);
        play(4, 4);
        play(0, 8);

        // Full FIFO: refusal, including push while popping when full
        st_q.delete();
        dn_q.delete();
        for (int i = 0; i < 8; i++) begin
            push(i[0], 16'hFFFF, 16'(i), 0);
        end
        chk("full_ready", int'(cmd_ready_o), 0);
        chk("full_level", int'(level_o), 8);
        cmd_valid_i = 1'b1;
        cmd_mask_i  = 16'hDEAD;
        cmd_data_i  = 16'hBEEF;
        tick();
        chk("full_refuse", int'(level_o), 8);
        start_i = 1'b1;
        t = cyc;
        tick();
        start_i     = 1'b0;
        cmd_valid_i = 1'b0;
        chk("full_pop_level", int'(level_o), 7);
        chk("full_pop_ready", int'(cmd_ready_o), 1);
        wait_done(40);
        chk("full_strobes", st_q.size(), 8);
        if (dn_q.size() > 0) chk("full_done_time", dn_q[0], t + 9);

        // Abort in the 3rd HOLD cycle of the first step
        st_q.delete();
        dn_q.delete();
        push(1'b0, 16'h0003, 16'h0001, 5);
        push(1'b1, 16'h0003, 16'h0002, 5);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        tick();
        abort_i     = 1'b1;
        cmd_valid_i = 1'b1;
        tick();
        abort_i     = 1'b0;
        cmd_valid_i = 1'b0;
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_level", int'(level_o), 0);
        chk("abort_strobe", int'(mo_lower_qe_o | mo_upper_qe_o), 0);
        exp_q.delete();
        for (int i = 0; i < 12; i++) tick();
        chk("abort_no_done", dn_q.size(), 0);
        chk("abort_strobes", st_q.size(), 1);
        chk("abort_level2", int'(level_o), 0);

        // Push during HOLD is played at the next decision
        st_q.delete();
        dn_q.delete();
        push(1'b0, 16'h00F0, 16'h0050, 4);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        push(1'b1, 16'h0F00, 16'h0500, 2);
        wait_done(30);
        chk("late_strobes", st_q.size(), 2);
        if (st_q.size() >= 2) begin
            chk("late_gap", st_q[1] - st_q[0], 5);
            if (dn_q.size() > 0) chk("late_done", dn_q[0], st_q[1] + 3);
        end

        // Push in the decision cycle is not seen by that decision
        st_q.delete();
        dn_q.delete();
        push(1'b0, 16'h0011, 16'h0022, 2);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        ts = cyc;
        tick();
        tick();
        push(1'b1, 16'h0033, 16'h0044, 0);
        wait_done(10);
        chk("dec_strobes", st_q.size(), 1);
        if (dn_q.size() > 0) chk("dec_done", dn_q[0], ts + 3);
        chk("dec_level", int'(level_o), 1);
        dn_q.delete();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(10);
        chk("dec_strobes2", st_q.size(), 2);
        chk("dec_level2", int'(level_o), 0);

        // Async reset in HOLD, then start with an empty FIFO
        st_q.delete();
        dn_q.delete();
        push(1'b0, 16'h1111, 16'h2222, 6);
        push(1'b1, 16'h3333, 16'h4444, 6);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_level", int'(level_o), 0);
        chk("arst_ready", int'(cmd_ready_o), 1);
        chk("arst_strobe", int'(mo_lower_qe_o | mo_upper_qe_o), 0);
        chk("arst_md", int'(mo_mask_o | mo_data_o), 0);
        chk("arst_done", int'(done_o), 0);
        exp_q.delete();
        tick();
        rst_ni = 1'b1;
        tick();
        st_q.delete();
        dn_q.delete();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("empty_start_strobes", st_q.size(), 0);
        chk("empty_start_done", dn_q.size(), 0);
        chk("empty_start_busy", int'(busy_o), 0);

        chk("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_wave_seq.md
Name: gpio_wave_seq

Overview:
- Hardware sequencer that plays a queued list of timed masked-output writes onto the GPIO output register.
- Drives the same masked write strobe/mask/data fields that the register block normally presents to the GPIO core (lower half = pins 15:0, upper half = pins 31:16).
- Software or a DMA loads steps into an internal FIFO, then pulses start. The block issues each write and holds it for a programmed number of cycles. This gives cycle-exact bit-banged waveforms without CPU timing jitter.
- Sits beside the GPIO register interface. Its strobes are ORed/muxed into the GPIO masked-out path by the integrating top.

Parameters:
- Depth, 8, FIFO entries; power of 2, ≥2.
- HoldW, 16, width of the per-step hold counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  step push request
- cmd_ready_o  out  1  FIFO can accept a step
- cmd_upper_i  in  1  0 = target pins 15:0, 1 = pins 31:16
- cmd_mask_i  in  16  bit-enable for the masked write
- cmd_data_i  in  16  data for the masked write
- cmd_hold_i  in  HoldW  extra cycles to hold after the write
- start_i  in  1  begin playback (pulse)
- abort_i  in  1  stop playback and flush the FIFO (pulse)
- mo_lower_qe_o  out  1  write strobe, lower half
- mo_upper_qe_o  out  1  write strobe, upper half
- mo_mask_o  out  16  mask for the active strobe
- mo_data_o  out  16  data for the active strobe
- busy_o  out  1  playback in progress
- done_o  out  1  one-cycle pulse when playback completes normally
- level_o  out  $clog2(Depth)+1  FIFO occupancy

Behaviour:
- Reset: all outputs 0 except cmd_ready_o = 1. FIFO empty, FSM in IDLE, counter 0.
- FIFO:
  - Push occurs when cmd_valid_i && cmd_ready_o.
  - cmd_ready_o = (level < Depth), computed from the registered level only. When full, a push is refused even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo Depth.
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE: start_i && level != 0 → ISSUE. start_i with an empty FIFO is ignored; no done_o.
  - ISSUE (one cycle):
    - Pop the head entry.
    - Assert mo_upper_qe_o if its upper flag is 1, otherwise mo_lower_qe_o. Exactly one strobe is asserted.
    - Drive mo_mask_o/mo_data_o with the entry's mask/data.
    - Load the counter with the entry's hold.
    - If hold != 0 → HOLD.
    - If hold == 0: go to ISSUE again if the FIFO still holds entries after this pop, otherwise finish.
  - HOLD: decrement the counter each cycle. When the counter reaches 1 and is then consumed:
    - FIFO non-empty → ISSUE.
    - FIFO empty → finish.
  - Finish: done_o = 1 for one cycle, busy_o = 0 in that same cycle, FSM returns to IDLE.
- Outputs:
  - Strobe, mask and data are registered.
  - mask/data read 0 whenever no strobe is asserted.
  - busy_o = 1 in ISSUE and HOLD.
- Timing:
  - start_i sampled at cycle t → first strobe at t+1.
  - Strobe for step k at cycle T → next strobe at T+1+hold_k.
  - The last step finishes with done_o at T_last+1+hold_last.
- Pushes during playback are allowed and are played if they are present when the next ISSUE/finish decision is made. A push in the same cycle as the decision is not visible to it.
- start_i while busy is ignored.
- abort_i has priority over everything, in any state:
  - Next cycle: FIFO is empty, FSM is IDLE, strobes are 0, busy_o = 0, and no done_o is produced.
  - A push in the same cycle as abort_i is discarded.
- Reset mid-playback: immediate return to the reset values, with no strobe glitch beyond the async clear.
- Counter arithmetic is unsigned HoldW bits. hold = 2^HoldW−1 is legal and does not wrap.

Test Plan:
- Push 1 step (upper=0, mask=16'h00FF, data=16'h00A5, hold=3), start at cycle 10 → mo_lower_qe_o=1 at cycle 11 with mask 00FF/data 00A5; busy 11–14; done_o at cycle 15; level 0.
- Push 3 steps with hold=0 (upper 0,1,0), start → strobes on 3 consecutive cycles, alternating lower/upper/lower; done_o on the 4th cycle.
- Fill 8 steps → cmd_ready_o=0, level_o=8. A 9th valid is not accepted. Start → after the first pop, cmd_ready_o=1 the following cycle.
- Start with 2 steps of hold=5; abort_i in the 3rd HOLD cycle of step 1 → next cycle busy=0, level=0, no second strobe, no done_o.
- Start with 1 step of hold=4; push a second step 2 cycles after the first strobe → the second strobe occurs exactly 5 cycles after the first; done_o follows after the second step's hold.
- Assert rst_ni low during HOLD → all outputs 0 asynchronously, cmd_ready_o=1. A subsequent start with an empty FIFO → no strobe, no done_o.
